ad9866_spi_ctrl: RTL

Sequences the AD9866 codec's control interface. It runs a hardware reset pulse, then plays an initialization register table through the AD9866 serial port. After that it arbitrates runtime register writes from two requesters: host command decoder on port 0 and gain control on port 1. It sits between the core's control logic and the codec pins `ad9866_rst_n`, `ad9866_sclk`, `ad9866_sdio` and `ad9866_sen_n`.

---
 rtl/ad9866_spi_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/ad9866_spi_ctrl.sv
// ad9866_spi_ctrl: AD9866 reset pulse, init-table playback, then round-robin
// arbitration of runtime register writes onto the codec serial port.
module ad9866_spi_ctrl #(
   parameter int CLK_DIV    = 4,
   parameter int RST_CYCLES = 64,
   parameter int INIT_LEN   = 8
) (
   input  logic        clk,
   input  logic        rst,
   output logic [4:0]  init_idx,
   input  logic [12:0] init_word,
   input  logic        req0_valid,
   input  logic [4:0]  req0_addr,
   input  logic [7:0]  req0_data,
   output logic        req0_ack,
   input  logic        req1_valid,
   input  logic [4:0]  req1_addr,
   input  logic [7:0]  req1_data,
   output logic        req1_ack,
   output logic        init_done,
   output logic        busy,
   output logic        ad9866_rst_n,
   output logic        ad9866_sclk,
   output logic        ad9866_sdio,
   output logic        ad9866_sen_n
);
   localparam int HW = $clog2(CLK_DIV) + 1;
   localparam int RW = $clog2(RST_CYCLES) + 1;
   localparam logic [HW-1:0] HALF_END = HW'(CLK_DIV - 1);
   localparam logic [HW-1:0] GAP_END  = HW'(2 * CLK_DIV - 1);
   localparam logic [RW-1:0] RST_END  = RW'(RST_CYCLES - 1);
   localparam logic [4:0]    LAST_IDX = 5'(INIT_LEN - 1);
   typedef enum logic [2:0] {RST_HOLD, RST_WAIT, INIT_FETCH, SHIFT, GAP, IDLE} state_t;
   state_t state, nxt;
   logic [1:0] rst_sync;
   logic rst_q;
   logic [HW-1:0] hc;
   logic [RW-1:0] rc;
   logic [3:0] bc;
   logic [15:0] sr;
   logic last, grant, take, hc_end;
   assign rst_q = rst_sync[1];
   assign ad9866_sdio = sr[15];
   // asserts together with rst, releases two clocks after it
   always_ff @(posedge clk or posedge rst)
      if (rst) rst_sync <= 2'b11;
      else rst_sync <= {rst_sync[0], 1'b0};
   always_comb begin
      hc_end = hc == HALF_END;
      grant = req1_valid && (!req0_valid || !last);
      take = state == IDLE && init_done && (req0_valid || req1_valid);
      nxt = state;
      case (state)
         RST_HOLD:   nxt = rc == RST_END ? RST_WAIT : RST_HOLD;
         RST_WAIT:   nxt = rc == RST_END ? INIT_FETCH : RST_WAIT;
         INIT_FETCH: nxt = rc == RW'(1) ? SHIFT : INIT_FETCH;
         SHIFT:      nxt = hc_end && ad9866_sclk && bc == 4'd15 ? GAP : SHIFT;
         GAP:        nxt = hc != GAP_END ? GAP : !init_done && init_idx != LAST_IDX ? INIT_FETCH : IDLE;
         IDLE:       nxt = take ? SHIFT : IDLE;
         default:    nxt = RST_HOLD;
      endcase
   end
   always_ff @(posedge clk or posedge rst_q)
      if (rst_q) begin
         state <= RST_HOLD;
         rc <= '0;
         hc <= '0;
         bc <= '0;
         sr <= '0;
         last <= 1'b1;
         init_idx <= '0;
         init_done <= 1'b0;
         busy <= 1'b1;
         ad9866_rst_n <= 1'b0;
         ad9866_sclk <= 1'b0;
         ad9866_sen_n <= 1'b1;
         req0_ack <= 1'b0;
         req1_ack <= 1'b0;
      end else begin
         state <= nxt;
         rc <= nxt != state ? '0 : rc + 1'b1;
         hc <= nxt != state || (state == SHIFT && hc_end) ? '0 : hc + 1'b1;
         busy <= nxt != IDLE;
         ad9866_rst_n <= nxt != RST_HOLD;
         ad9866_sen_n <= nxt != SHIFT;
         req0_ack <= take && !grant;
         req1_ack <= take && grant;
         if (take) last <= grant;
         // data moves on at the end of each high phase, so SDIO only changes while SCLK is low
         if (state == INIT_FETCH && nxt == SHIFT) sr <= {3'b000, init_word};
         else if (take) sr <= {3'b000, grant ? req1_addr : req0_addr, grant ? req1_data : req0_data};
         else if (state == SHIFT && hc_end && ad9866_sclk) begin
            sr <= sr << 1;
            bc <= bc + 1'b1;
         end
         if (state == SHIFT && hc_end) ad9866_sclk <= !ad9866_sclk;
         if (state == GAP && nxt != GAP && !init_done) begin
            if (init_idx == LAST_IDX) init_done <= 1'b1;
            else init_idx <= init_idx + 1'b1;
         end
      end
endmodule
